dram_master_arbiter: RTL

- Shares the single Avalon-MM DRAM master port of DeltaAcc among NUM_REQ internal requesters (e.g. weight fetch, activation fetch, output writeback).
- Single-word transfers, one outstanding at a time, round-robin fairness.
- Sits between the DeltaAcc datapath engines and the top-level DRAM_master_* pins.

---
 rtl/dram_master_arbiter_pkg.sv | 9 +
 rtl/dram_master_arbiter_if.sv | 48 ++++
 rtl/dram_master_arbiter_rr_picker.sv | 23 ++
 rtl/dram_master_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/dram_master_arbiter_pkg.sv
// dram_arb_pkg: shared types and defaults for the DRAM master arbiter.
package dram_arb_pkg;
  typedef enum logic [0:0] {ARB_IDLE, ARB_ISSUE} arb_state_t;
  localparam int ARB_NUM_REQ = 3;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_TIMEOUT_CYC = 1023;
  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/dram_master_arbiter_if.sv
// dram_master_arbiter_if: requester and Avalon-MM DRAM master signals of the arbiter.
// timeout_err exists only when DRAM_ARB_TIMEOUT_EN is defined.
interface dram_master_arbiter_if
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0][DATA_W/8-1:0] req_byteen;
  logic [NUM_REQ-1:0] resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic busy;
  logic DRAM_master_WaitRequest;
  logic DRAM_master_Read;
  logic DRAM_master_Write;
  logic [ADDR_W-1:0] DRAM_master_Address;
  logic [DATA_W/8-1:0] DRAM_master_ByteEnable;
  logic [DATA_W-1:0] DRAM_master_ReadData;
  logic [DATA_W-1:0] DRAM_master_WriteData;
`ifdef DRAM_ARB_TIMEOUT_EN
  logic timeout_err;
`endif
  modport master (
    input req_valid, req_write, req_addr, req_wdata, req_byteen,
    input DRAM_master_WaitRequest, DRAM_master_ReadData,
    output resp_valid, resp_rdata, busy,
    output DRAM_master_Read, DRAM_master_Write, DRAM_master_Address,
    output DRAM_master_ByteEnable, DRAM_master_WriteData
`ifdef DRAM_ARB_TIMEOUT_EN
    , output timeout_err
`endif
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_byteen,
    output DRAM_master_WaitRequest, DRAM_master_ReadData,
    input resp_valid, resp_rdata, busy,
    input DRAM_master_Read, DRAM_master_Write, DRAM_master_Address,
    input DRAM_master_ByteEnable, DRAM_master_WriteData
`ifdef DRAM_ARB_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/dram_master_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector; searches upward from start, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!any && req[(int'(start) + i) % NUM_REQ]) begin
        any = 1'b1;
        grant[(int'(start) + i) % NUM_REQ] = 1'b1;
        idx = IDX_W'((int'(start) + i) % NUM_REQ);
      end
  end
endmodule

// File: rtl/dram_master_arbiter.sv
// dram_master_arbiter: round-robin sharing of one Avalon-MM DRAM master, one word in flight.
// Define DRAM_ARB_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYC cycles.
module dram_master_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
`ifdef DRAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
`endif
) (
  input logic clock,
  input logic reset,
  dram_master_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  arb_state_t state, state_n;
  logic [IDX_W-1:0] ptr, winner, pick_idx;
  logic [NUM_REQ-1:0] owner, pick_grant;
  logic pick_any, grant_go, done, abort;
  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req(bus.req_valid), .start(ptr), .grant(pick_grant), .idx(pick_idx), .any(pick_any)
  );
`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  assign abort = state == ARB_ISSUE && bus.DRAM_master_WaitRequest && wait_cnt == CNT_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wait_cnt <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      wait_cnt <= grant_go ? '0 : (state == ARB_ISSUE && bus.DRAM_master_WaitRequest) ? wait_cnt + 1'b1 : wait_cnt;
      bus.timeout_err <= bus.timeout_err | abort;
    end
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= ARB_IDLE;
    else state <= state_n;
  always_comb begin
    grant_go = state == ARB_IDLE && pick_any;
    done = state == ARB_ISSUE && (!bus.DRAM_master_WaitRequest || abort);
    state_n = grant_go ? ARB_ISSUE : done ? ARB_IDLE : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ptr <= '0;
      winner <= '0;
      owner <= '0;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      bus.busy <= 1'b0;
      bus.DRAM_master_Read <= 1'b0;
      bus.DRAM_master_Write <= 1'b0;
      bus.DRAM_master_Address <= '0;
      bus.DRAM_master_ByteEnable <= '0;
      bus.DRAM_master_WriteData <= '0;
    end else begin
      bus.resp_valid <= done ? owner : '0;
      if (grant_go) begin
        winner <= pick_idx;
        owner <= pick_grant;
        bus.busy <= 1'b1;
        bus.DRAM_master_Read <= ~bus.req_write[pick_idx];
        bus.DRAM_master_Write <= bus.req_write[pick_idx];
        bus.DRAM_master_Address <= bus.req_addr[pick_idx];
        bus.DRAM_master_ByteEnable <= bus.req_byteen[pick_idx];
        bus.DRAM_master_WriteData <= bus.req_wdata[pick_idx];
      end
      if (done) begin
        ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        bus.busy <= 1'b0;
        bus.DRAM_master_Read <= 1'b0;
        bus.DRAM_master_Write <= 1'b0;
        bus.resp_rdata <= abort ? DATA_W'(ARB_TIMEOUT_DATA) : bus.DRAM_master_Read ? bus.DRAM_master_ReadData : bus.resp_rdata;
      end
    end
endmodule
